ccff_chain_loader: RTL and testbench
====================================

Name: ccff_chain_loader

Overview:
- Configuration-chain controller for the fabric's routing muxes.
- Accepts bitstream words over a valid/ready handshake and serialises them LSB-first onto the configuration flip-flop (CCFF) shift chain.
- The chain holds the sram select bits of the mux_tree_tapbuf instances.
- Counts shifted bits, stops after exactly CHAIN_LEN bits and reports completion; sits between the bitstream source and the head of a tile's CCFF chain.

Parameters:
- WORD_W, 8, width of incoming bitstream words (>=1).
- CHAIN_LEN, 40, number of CCFF bits in the chain (>=1); default is 20 size-2 muxes x 2 sram bits.
- CNT_W (localparam), $clog2(CHAIN_LEN+1), width of the bit counter.

Ports:
- prog_clk  input  1  programming clock; all state updates on its rising edge.
- prog_reset  input  1  synchronous, active-high reset.
- start  input  1  begin a chain load; sampled only in IDLE or DONE.
- abort  input  1  synchronous abort; returns to IDLE from any state.
- word_in  input  WORD_W  bitstream word; bit 0 is shifted first.
- word_valid  input  1  word_in valid.
- word_ready  output  1  loader accepts word_in this cycle.
- ccff_head  output  1  serial data to the chain head.
- ccff_shift_en  output  1  chain shift enable; chain captures ccff_head when high.
- busy  output  1  load in progress (LOAD or SHIFT).
- done  output  1  chain fully loaded; held until next start, abort or reset.
- bits_loaded  output  CNT_W  number of bits shifted in the current/last load.

Behaviour:
- Reset: prog_reset high at a rising edge puts the block in IDLE and clears shreg, bit_idx and bits_loaded. All outputs are 0 in the following cycle. Reset has priority over abort and start and takes effect in any state, including mid-word.
- Output timing: all outputs decode from registered state, shreg and counters. There is no combinational path from any input to any output.
- IDLE:
  - word_ready=0, ccff_shift_en=0, ccff_head=0, busy=0, done=0.
  - start=1 -> LOAD; bits_loaded cleared to 0.
- LOAD:
  - word_ready=1, busy=1, ccff_shift_en=0, ccff_head=0.
  - word_valid=1 -> capture word_in into shreg, bit_idx=0, go to SHIFT.
  - word_valid=0 -> stay in LOAD indefinitely; backpressure loses no bits.
- SHIFT:
  - ccff_shift_en=1, ccff_head=shreg[0], word_ready=0, busy=1.
  - At each edge: shreg shifts right by 1, bit_idx+1, bits_loaded+1.
  - bits_loaded == CHAIN_LEN-1 (this is the final bit) -> DONE.
  - Otherwise, bit_idx == WORD_W-1 -> LOAD.
  - Otherwise stay in SHIFT.
- DONE:
  - done=1, busy=0, ccff_shift_en=0, ccff_head=0; bits_loaded holds CHAIN_LEN.
  - start=1 -> LOAD, done=0, bits_loaded=0.
- Word accounting:
  - Words consumed = ceil(CHAIN_LEN/WORD_W).
  - Unused upper bits of the final word are discarded and never shifted.
  - Each word costs 1 LOAD cycle + WORD_W SHIFT cycles (the final word costs fewer SHIFT cycles when it is partial).
- Chain ordering: the first bit shifted ends farthest from the head, at the tail position CHAIN_LEN-1.
- start while busy: ignored; no state change and no error.
- abort: any state -> IDLE at the next edge; ccff_shift_en=0, done=0, bits_loaded=0. Chain contents are undefined after abort. abort and start in the same cycle: abort wins.
- Handshake: a transfer occurs only on word_valid & word_ready. word_in may change freely when no transfer occurs.

Test Plan:
- WORD_W=8, CHAIN_LEN=12, start, words 0xA5 then 0x3C:
  - ccff_head over shift cycles = 1,0,1,0,0,1,0,1 then 0,0,1,1.
  - ccff_shift_en high for exactly 12 cycles; exactly 2 handshakes.
  - done=1 with bits_loaded=12.
- Backpressure: hold word_valid=0 for 5 cycles in LOAD -> word_ready stays 1, ccff_shift_en=0, ccff_head=0; the shifted sequence is identical to the case with no stall.
- abort asserted after 5 shift cycles:
  - Next cycle: IDLE, ccff_shift_en=0, busy=0, done=0, bits_loaded=0.
  - A subsequent start performs a full 12-bit load.
- start pulsed during SHIFT -> ignored, bit count unaffected. start in DONE -> done drops next cycle, new load begins from bits_loaded=0.
- prog_reset asserted mid-SHIFT together with abort and start -> all outputs 0 the next cycle, state IDLE.
- CHAIN_LEN=16, WORD_W=8, words 0xFF, 0x00 -> 8 ones then 8 zeros, no discard, done after exactly 16 shift cycles, 2 handshakes.

Source files
------------

// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: accepts bitstream words over valid/ready and serialises
// them LSB-first onto a CCFF configuration shift chain. It stops after exactly
// CHAIN_LEN bits and holds a done flag until the next start, abort or reset.
module ccff_chain_loader #(
   parameter int WORD_W    = 8,
   parameter int CHAIN_LEN = 40,
   localparam int CNT_W    = $clog2(CHAIN_LEN + 1)
) (
   input  logic              prog_clk,
   input  logic              prog_reset,
   input  logic              start,
   input  logic              abort,
   input  logic [WORD_W-1:0] word_in,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              ccff_head,
   output logic              ccff_shift_en,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  bits_loaded
);

   localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t            state;
   logic [WORD_W-1:0] shreg;
   logic [WORD_W-1:0] shreg_nxt;
   logic [IDX_W-1:0]  bit_idx;

   // Word register after this cycle's shift; its bit 0 is the next head bit.
   always_comb begin
      shreg_nxt = shreg >> 1;
   end

   // Control FSM; every output is registered and set together with the state
   // it belongs to, so ccff_head is loaded one cycle ahead from the word value.
   always_ff @(posedge prog_clk) begin
      if (prog_reset) begin
         state         <= S_IDLE;
         shreg         <= '0;
         bit_idx       <= '0;
         bits_loaded   <= '0;
         word_ready    <= 1'b0;
         ccff_head     <= 1'b0;
         ccff_shift_en <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else if (abort) begin
         state         <= S_IDLE;
         bits_loaded   <= '0;
         word_ready    <= 1'b0;
         ccff_head     <= 1'b0;
         ccff_shift_en <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state       <= S_LOAD;
                  bits_loaded <= '0;
                  word_ready  <= 1'b1;
                  busy        <= 1'b1;
                  done        <= 1'b0;
               end
            end
            S_LOAD: begin
               if (word_valid) begin
                  state         <= S_SHIFT;
                  shreg         <= word_in;
                  bit_idx       <= '0;
                  word_ready    <= 1'b0;
                  ccff_shift_en <= 1'b1;
                  ccff_head     <= word_in[0];
               end
            end
            S_SHIFT: begin
               shreg       <= shreg_nxt;
               bit_idx     <= bit_idx + IDX_W'(1);
               bits_loaded <= bits_loaded + CNT_W'(1);
               if (bits_loaded == CNT_W'(CHAIN_LEN - 1)) begin
                  // Final chain bit: leftover bits of a partial word are dropped.
                  state         <= S_DONE;
                  ccff_shift_en <= 1'b0;
                  ccff_head     <= 1'b0;
                  busy          <= 1'b0;
                  done          <= 1'b1;
               end else if (bit_idx == IDX_W'(WORD_W - 1)) begin
                  state         <= S_LOAD;
                  ccff_shift_en <= 1'b0;
                  ccff_head     <= 1'b0;
                  word_ready    <= 1'b1;
               end else begin
                  ccff_head <= shreg_nxt[0];
               end
            end
            default: begin
               state         <= S_IDLE;
               word_ready    <= 1'b0;
               ccff_head     <= 1'b0;
               ccff_shift_en <= 1'b0;
               busy          <= 1'b0;
               done          <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Testbench for ccff_chain_loader: a 12-bit chain instance exercised with a
// vector table, random loads against a bit-queue reference and corner-case
// sequences, plus a 16-bit chain instance for the full-word case.
module tb_ccff_chain_loader;

   localparam int WW   = 8;
   localparam int CL_A = 12;
   localparam int CL_B = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic prog_reset;

   // Instance A: CHAIN_LEN = 12
   logic          start_a, abort_a, valid_a;
   logic [WW-1:0] in_a;
   logic          ready_a, head_a, sh_a, busy_a, done_a;
   logic [3:0]    bits_a;

   // Instance B: CHAIN_LEN = 16
   logic          start_b, abort_b, valid_b;
   logic [WW-1:0] in_b;
   logic          ready_b, head_b, sh_b, busy_b, done_b;
   logic [4:0]    bits_b;

   ccff_chain_loader #(.WORD_W(WW), .CHAIN_LEN(CL_A)) u_dut_a (
      .prog_clk      (clk),
      .prog_reset    (prog_reset),
      .start         (start_a),
      .abort         (abort_a),
      .word_in       (in_a),
      .word_valid    (valid_a),
      .word_ready    (ready_a),
      .ccff_head     (head_a),
      .ccff_shift_en (sh_a),
      .busy          (busy_a),
      .done          (done_a),
      .bits_loaded   (bits_a)
   );

   ccff_chain_loader #(.WORD_W(WW), .CHAIN_LEN(CL_B)) u_dut_b (
      .prog_clk      (clk),
      .prog_reset    (prog_reset),
      .start         (start_b),
      .abort         (abort_b),
      .word_in       (in_b),
      .word_valid    (valid_b),
      .word_ready    (ready_b),
      .ccff_head     (head_b),
      .ccff_shift_en (sh_b),
      .busy          (busy_b),
      .done          (done_b),
      .bits_loaded   (bits_b)
   );

   // Observers: shifted bits, handshakes, and a model of the physical chain
   bit            obs_a[$];
   bit            obs_b[$];
   int            hs_a = 0;
   int            hs_b = 0;
   logic [CL_A-1:0] chain_a = '0;

   always @(posedge clk) begin
      if (sh_a) begin
         obs_a.push_back(head_a);
         chain_a <= {chain_a[CL_A-2:0], head_a};
      end
      if (valid_a && ready_a) hs_a <= hs_a + 1;
      if (sh_b) obs_b.push_back(head_b);
      if (valid_b && ready_b) hs_b <= hs_b + 1;
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference: concatenate words LSB-first and keep the first CL_A bits
   function automatic logic [CL_A-1:0] ref_stream(input logic [WW-1:0] w0, input logic [WW-1:0] w1);
      bit q[$];
      logic [CL_A-1:0] s;
      for (int i = 0; i < WW; i++) q.push_back(w0[i]);
      for (int i = 0; i < WW; i++) q.push_back(w1[i]);
      s = '0;
      for (int k = 0; k < CL_A; k++) s[k] = q[k];
      return s;
   endfunction

   // First bit shifted sits at the tail (index CL_A-1)
   function automatic logic [CL_A-1:0] chain_of(input logic [CL_A-1:0] s);
      logic [CL_A-1:0] c;
      for (int k = 0; k < CL_A; k++) c[CL_A-1-k] = s[k];
      return c;
   endfunction

   // One complete load on instance A, optionally stalling and poking start mid-shift
   task automatic run_load(input string tag, input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                           input int stall, input bit poke, input logic [CL_A-1:0] exp);
      int base, hs0, widx, st, cyc, cnt;
      logic [CL_A-1:0] got;
      base = obs_a.size();
      hs0  = hs_a;
      widx = 0;
      st   = stall;
      cyc  = 0;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      check({tag, "_start"}, {28'd0, done_a, busy_a, ready_a, (bits_a == 4'd0)}, 32'h7);
      while (!done_a && cyc < 200) begin
         valid_a = 1'b0;
         in_a    = WW'($urandom);
         start_a = 1'b0;
         if (ready_a && widx < 2) begin
            if (st > 0) begin
               st--;
               check({tag, "_stall"}, {29'd0, busy_a, sh_a, head_a}, 32'h4);
            end else begin
               valid_a = 1'b1;
               in_a    = (widx == 0) ? w0 : w1;
               widx++;
               st = stall;
            end
         end
         if (poke && sh_a && (obs_a.size() - base) == 3) start_a = 1'b1;
         @(negedge clk);
         cyc++;
      end
      valid_a = 1'b0;
      start_a = 1'b0;
      cnt = obs_a.size() - base;
      got = '0;
      for (int k = 0; k < CL_A && k < cnt; k++) got[k] = obs_a[base + k];
      check({tag, "_done"}, {27'd0, done_a, busy_a, sh_a, ready_a, head_a}, 32'h10);
      check({tag, "_nshift"}, cnt, CL_A);
      check({tag, "_nhs"}, hs_a - hs0, 2);
      check({tag, "_bits"}, 32'(bits_a), CL_A);
      check({tag, "_stream"}, 32'(got), 32'(exp));
      check({tag, "_chain"}, 32'(chain_a), 32'(chain_of(exp)));
      @(negedge clk);
      check({tag, "_hold"}, {27'd0, done_a, bits_a}, {27'd1, 4'(CL_A)});
   endtask

   typedef struct {
      logic [WW-1:0]   w0;
      logic [WW-1:0]   w1;
      int              stall;
      bit              poke;
      logic [CL_A-1:0] exp;
   } vec_t;

   vec_t tbl[6];

   initial begin
      int base, cyc, widx, cnt;
      logic [WW-1:0]   r0, r1;
      logic [CL_B-1:0] gb;

      tbl[0] = '{w0: 8'hA5, w1: 8'h3C, stall: 0, poke: 1'b0, exp: 12'hCA5};
      tbl[1] = '{w0: 8'hA5, w1: 8'h3C, stall: 5, poke: 1'b0, exp: 12'hCA5};
      tbl[2] = '{w0: 8'hFF, w1: 8'h00, stall: 0, poke: 1'b0, exp: 12'h0FF};
      tbl[3] = '{w0: 8'h00, w1: 8'hFF, stall: 2, poke: 1'b0, exp: 12'hF00};
      tbl[4] = '{w0: 8'h12, w1: 8'hF7, stall: 1, poke: 1'b0, exp: 12'h712};
      tbl[5] = '{w0: 8'hA5, w1: 8'h3C, stall: 0, poke: 1'b1, exp: 12'hCA5};

      prog_reset = 1'b1;
      start_a = 1'b0; abort_a = 1'b0; valid_a = 1'b0; in_a = '0;
      start_b = 1'b0; abort_b = 1'b0; valid_b = 1'b0; in_b = '0;
      repeat (2) @(negedge clk);
      prog_reset = 1'b0;
      check("reset_a", {23'd0, ready_a, head_a, sh_a, busy_a, done_a, bits_a}, 32'h0);
      check("reset_b", {22'd0, ready_b, head_b, sh_b, busy_b, done_b, bits_b}, 32'h0);
      @(negedge clk);

      foreach (tbl[i]) run_load("tbl", tbl[i].w0, tbl[i].w1, tbl[i].stall, tbl[i].poke, tbl[i].exp);

      for (int i = 0; i < 16; i++) begin
         r0 = WW'($urandom);
         r1 = WW'($urandom);
         run_load("rnd", r0, r1, int'($urandom_range(0, 4)), 1'b0, ref_stream(r0, r1));
      end

      // Abort partway through the first word
      base = obs_a.size();
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      cyc = 0;
      widx = 0;
      while ((obs_a.size() - base) < 5 && cyc < 50) begin
         valid_a = (ready_a && widx == 0);
         in_a    = 8'hA5;
         if (valid_a) widx++;
         @(negedge clk);
         cyc++;
      end
      valid_a = 1'b0;
      check("abort_reach", obs_a.size() - base, 5);
      abort_a = 1'b1;
      @(negedge clk);
      abort_a = 1'b0;
      check("abort_out", {23'd0, ready_a, head_a, sh_a, busy_a, done_a, bits_a}, 32'h0);
      run_load("post_abort", 8'h5A, 8'hC3, 0, 1'b0, ref_stream(8'h5A, 8'hC3));

      // Reset together with abort and start, mid-shift
      base = obs_a.size();
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      cyc = 0;
      widx = 0;
      while ((obs_a.size() - base) < 3 && cyc < 50) begin
         valid_a = (ready_a && widx == 0);
         in_a    = 8'h3C;
         if (valid_a) widx++;
         @(negedge clk);
         cyc++;
      end
      valid_a = 1'b0;
      check("rst_reach", {31'd0, sh_a}, 32'h1);
      prog_reset = 1'b1; abort_a = 1'b1; start_a = 1'b1;
      @(negedge clk);
      check("rst_mid", {23'd0, ready_a, head_a, sh_a, busy_a, done_a, bits_a}, 32'h0);
      prog_reset = 1'b0; abort_a = 1'b0; start_a = 1'b0;
      @(negedge clk);
      check("rst_idle", {23'd0, ready_a, head_a, sh_a, busy_a, done_a, bits_a}, 32'h0);

      // 16-bit chain: two full words, nothing discarded
      base = obs_b.size();
      widx = hs_b;
      start_b = 1'b1;
      @(negedge clk);
      start_b = 1'b0;
      cyc = 0;
      cnt = 0;
      while (!done_b && cyc < 200) begin
         valid_b = 1'b0;
         in_b    = WW'($urandom);
         if (ready_b && cnt < 2) begin
            valid_b = 1'b1;
            in_b    = (cnt == 0) ? 8'hFF : 8'h00;
            cnt++;
         end
         @(negedge clk);
         cyc++;
      end
      valid_b = 1'b0;
      gb = '0;
      for (int k = 0; k < CL_B && k < (obs_b.size() - base); k++) gb[k] = obs_b[base + k];
      check("b16_done", {30'd0, done_b, busy_b}, 32'h2);
      check("b16_nshift", obs_b.size() - base, CL_B);
      check("b16_nhs", hs_b - widx, 2);
      check("b16_bits", 32'(bits_b), CL_B);
      check("b16_stream", 32'(gb), 32'h00FF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
